image_conv_pipe: RTL and testbench
==================================

Name: image_conv_pipe

Overview:
- Parametrised, pipelined 3x3 convolution engine on the DXI valid/ready stream. It is the successor of the single-channel fixed-mask image processor.
- Adds NUM_CH parallel channels, a fourth-generation user-programmable kernel with shift normalisation, saturation reporting and full backpressure support.
- Sits between the line-buffer/window generator (upstream DXI) and the pixel writer (downstream DXI).

Parameters:
- DATA_BW, 8, unsigned pixel width.
- NUM_CH, 1, channels processed in parallel per beat, all with the same kernel.
- COEF_BW, 8, signed width of user-programmable coefficients.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_config_select  in  3  mode; sampled with each accepted input beat.
- i_coef_wr_en  in  1  user-coefficient write strobe.
- i_coef_addr  in  4  coefficient index 0..8; 9..15 ignored.
- i_coef_data  in  COEF_BW  signed coefficient.
- i_user_shift  in  4  right shift for user mode; sampled with each beat.
- i_dxi_in_valid  in  1  input beat valid.
- i_dxi_in_data  in  DATA_BW*9*NUM_CH  windows.
- o_dxi_in_ready  out  1  input accept.
- o_dxi_out_valid  out  1  output valid.
- o_dxi_out_data  out  DATA_BW*NUM_CH  filtered pixels; channel c at [c*DATA_BW +: DATA_BW].
- i_dxi_out_ready  in  1  downstream accept.
- o_sat_flag  out  1  beat-aligned with output: any channel clamped.

Behaviour:
- Window layout:
  - Channel c occupies [c*9*DATA_BW +: 9*DATA_BW].
  - Pixel k (k=0..8, row-major, top-left first) sits at [(9-k)*DATA_BW-1 -: DATA_BW] within the channel.
  - Kernel index k pairs with pixel k.
- Modes:
  - 000 lap1 {0,-1,0,-1,4,-1,0,-1,0}, norm none.
  - 001 lap2 {-1,-1,-1,-1,8,-1,-1,-1,-1}, norm none.
  - 010 gauss {1,2,1,2,4,2,1,2,1}, arithmetic >>4.
  - 011 avg all 1, floor(sum/9) for sum>=0.
  - 100 user: coef RAM, arithmetic >> i_user_shift (floor toward -inf).
  - 101..111 bypass: output = pixel 4, no saturation.
- Arithmetic:
  - Pixels zero-extended.
  - Signed accumulator of DATA_BW+COEF_BW+5 bits; no internal overflow is possible.
  - After normalisation, clamp: <0 -> 0, >2^DATA_BW-1 -> 2^DATA_BW-1.
  - o_sat_flag=1 if any channel clamped.
- Pipeline: 3 stages.
  - S1 latches window, mode and shift, and computes products.
  - S2 runs the adder tree.
  - S3 normalises and clamps into the output register.
  - Latency: accept at cycle N -> o_dxi_out_valid at N+3 when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - adv = !o_dxi_out_valid || i_dxi_out_ready.
  - o_dxi_in_ready = adv (combinational).
  - A beat is accepted when i_dxi_in_valid && o_dxi_in_ready.
  - All stages shift on adv. Stage valid bits propagate, so bubbles travel as invalid.
  - When !adv, every stage holds. o_dxi_out_data and o_sat_flag stay stable while valid && !ready.
  - o_dxi_out_valid never drops without a handshake.
- Coefficients:
  - 9 x COEF_BW register file; reset value all 0.
  - A write in cycle N is visible to beats accepted in cycle N+1 or later. Beats already in flight use their S1-captured products.
  - Simultaneous write and accept in the same cycle: the accepted beat uses the old value.
- Reset:
  - i_rstn low at a rising edge clears all stage valids, o_dxi_out_valid=0, o_dxi_out_data=0, o_sat_flag=0 and the coef RAM.
  - Mid-operation reset drops in-flight beats; no partial output.
  - o_dxi_in_ready is 1 in the cycle after reset because adv=1.

Test Plan:
- Mode 000, DATA_BW=8, center=10, others 0 -> out 40, sat 0, valid 3 cycles after accept.
- Mode 000, center 0, neighbours 10 -> sum -40 -> out 0, sat 1; mode 001 all 255 -> out 0, sat 0.
- Mode 010 all 100 -> 100. Mode 011 pixels 0..8 -> 36/9 = 4. Mode 011 all 255 -> 255, sat 0.
- User mode: write coef[k]=k (0..8), shift 2, all pixels 255 -> 36*255=9180, >>2=2295 -> 255, sat 1. Then write coef[4]=-1 with the other coefs zeroed, shift 0 -> out 0, sat 1. Verify a write in the same cycle as accept uses the old value.
- Backpressure: 6 back-to-back beats, i_dxi_out_ready low for 5 cycles after the first output. Outputs must stay stable, o_dxi_in_ready low, all 6 beats delivered in order with no loss or duplication. Also run random valid/ready with a scoreboard.
- NUM_CH=3, mixed modes per beat (000, 010, 101 alternating) -> per-channel results match the model and the mode tracks its own beat. Assert i_rstn low with 3 beats in flight -> no outputs appear afterwards, all outputs are 0 and coefs are cleared.

Source files
------------

// File: rtl/image_conv_pipe.sv
// Three-stage 3x3 convolution over NUM_CH parallel channels sharing one kernel.
// Built-in Laplacian/Gaussian/box kernels, a programmable kernel and a centre-pixel bypass.
module image_conv_pipe #(
   parameter int DATA_BW = 8,
   parameter int NUM_CH  = 1,
   parameter int COEF_BW = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic [2:0]                  i_config_select,
   input  logic                        i_coef_wr_en,
   input  logic [3:0]                  i_coef_addr,
   input  logic [COEF_BW-1:0]          i_coef_data,
   input  logic [3:0]                  i_user_shift,
   input  logic                        i_dxi_in_valid,
   input  logic [DATA_BW*9*NUM_CH-1:0] i_dxi_in_data,
   output logic                        o_dxi_in_ready,
   output logic                        o_dxi_out_valid,
   output logic [DATA_BW*NUM_CH-1:0]   o_dxi_out_data,
   input  logic                        i_dxi_out_ready,
   output logic                        o_sat_flag
);
   localparam int PROD_W = DATA_BW + COEF_BW + 1;
   localparam int ACC_W  = DATA_BW + COEF_BW + 5;

   localparam logic [2:0] MODE_LAP1  = 3'd0;
   localparam logic [2:0] MODE_LAP2  = 3'd1;
   localparam logic [2:0] MODE_GAUSS = 3'd2;
   localparam logic [2:0] MODE_AVG   = 3'd3;
   localparam logic [2:0] MODE_USER  = 3'd4;

   localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_BW) - 1);
   localparam logic signed [ACC_W-1:0] AVG_DIV = ACC_W'(9);

   // Bypass is a unit centre tap with no normalisation, so it can never clamp.
   function automatic logic signed [COEF_BW-1:0] kern_coef(
      input logic [2:0]                mode,
      input int                        k,
      input logic signed [COEF_BW-1:0] user_c
   );
      int v;
      case (mode)
         MODE_LAP1:  v = (k == 4) ? 4 : ((k % 2 == 1) ? -1 : 0);
         MODE_LAP2:  v = (k == 4) ? 8 : -1;
         MODE_GAUSS: v = (k == 4) ? 4 : ((k % 2 == 1) ? 2 : 1);
         MODE_AVG:   v = 1;
         MODE_USER:  v = int'(user_c);
         default:    v = (k == 4) ? 1 : 0;
      endcase
      return COEF_BW'(v);
   endfunction

   function automatic logic signed [PROD_W-1:0] mul_pix(
      input logic [DATA_BW-1:0]        pix,
      input logic signed [COEF_BW-1:0] c
   );
      logic signed [PROD_W-1:0] a;
      logic signed [PROD_W-1:0] b;
      a = $signed({{(PROD_W-DATA_BW){1'b0}}, pix});
      b = {{(PROD_W-COEF_BW){c[COEF_BW-1]}}, c};
      return a * b;
   endfunction

   function automatic logic signed [ACC_W-1:0] normalise(
      input logic signed [ACC_W-1:0] acc,
      input logic [2:0]              mode,
      input logic [3:0]              shift
   );
      logic signed [ACC_W-1:0] r;
      case (mode)
         MODE_GAUSS: r = acc >>> 4;
         MODE_AVG:   r = acc / AVG_DIV;
         MODE_USER:  r = acc >>> shift;
         default:    r = acc;
      endcase
      return r;
   endfunction

   // Returns {clamped, pixel}.
   function automatic logic [DATA_BW:0] clamp_pix(input logic signed [ACC_W-1:0] v);
      logic [DATA_BW:0] r;
      if (v < 0)            r = {1'b1, {DATA_BW{1'b0}}};
      else if (v > PIX_MAX) r = {1'b1, {DATA_BW{1'b1}}};
      else                  r = {1'b0, v[DATA_BW-1:0]};
      return r;
   endfunction

   logic                      adv;
   logic signed [COEF_BW-1:0] coef_q [9];
   logic signed [COEF_BW-1:0] coef_d [9];

   logic                      vld_p1_q, vld_p1_d;
   logic [2:0]                mode_p1_q, mode_p1_d;
   logic [3:0]                shift_p1_q, shift_p1_d;
   logic signed [PROD_W-1:0]  prod_p1_q [NUM_CH][9];
   logic signed [PROD_W-1:0]  prod_p1_d [NUM_CH][9];

   logic                      vld_p2_q, vld_p2_d;
   logic [2:0]                mode_p2_q, mode_p2_d;
   logic [3:0]                shift_p2_q, shift_p2_d;
   logic signed [ACC_W-1:0]   sum_p2_q [NUM_CH];
   logic signed [ACC_W-1:0]   sum_p2_d [NUM_CH];

   logic                      vld_p3_q, vld_p3_d;
   logic [DATA_BW*NUM_CH-1:0] pix_p3_q, pix_p3_d;
   logic                      sat_p3_q, sat_p3_d;

   assign adv             = !vld_p3_q || i_dxi_out_ready;
   assign o_dxi_in_ready  = adv;
   assign o_dxi_out_valid = vld_p3_q;
   assign o_dxi_out_data  = pix_p3_q;
   assign o_sat_flag      = sat_p3_q;

   // A write lands at the clock edge, so a beat accepted on that same edge still sees the old value.
   always_comb begin
      coef_d = coef_q;
      if (i_coef_wr_en && (i_coef_addr < 4'd9)) begin
         coef_d[i_coef_addr] = i_coef_data;
      end
   end

   // ---- S1: capture window controls and form products ----
   always_comb begin
      vld_p1_d   = vld_p1_q;
      mode_p1_d  = mode_p1_q;
      shift_p1_d = shift_p1_q;
      prod_p1_d  = prod_p1_q;
      if (adv) begin
         vld_p1_d   = i_dxi_in_valid;
         mode_p1_d  = i_config_select;
         shift_p1_d = i_user_shift;
         for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < 9; k++) begin
               prod_p1_d[c][k] = mul_pix(i_dxi_in_data[c*9*DATA_BW + (8-k)*DATA_BW +: DATA_BW],
                                         kern_coef(i_config_select, k, coef_q[k]));
            end
         end
      end
   end

   // ---- S2: sum the nine taps per channel ----
   always_comb begin
      vld_p2_d   = vld_p2_q;
      mode_p2_d  = mode_p2_q;
      shift_p2_d = shift_p2_q;
      sum_p2_d   = sum_p2_q;
      if (adv) begin
         vld_p2_d   = vld_p1_q;
         mode_p2_d  = mode_p1_q;
         shift_p2_d = shift_p1_q;
         for (int c = 0; c < NUM_CH; c++) begin
            sum_p2_d[c] = '0;
            for (int k = 0; k < 9; k++) begin
               sum_p2_d[c] = sum_p2_d[c] + ACC_W'(prod_p1_q[c][k]);
            end
         end
      end
   end

   // ---- S3: normalise, clamp, register output; bubbles leave the output data untouched ----
   always_comb begin
      logic [DATA_BW:0] clamped;
      clamped  = '0;
      vld_p3_d = vld_p3_q;
      pix_p3_d = pix_p3_q;
      sat_p3_d = sat_p3_q;
      if (adv) begin
         vld_p3_d = vld_p2_q;
         if (vld_p2_q) begin
            sat_p3_d = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
               clamped = clamp_pix(normalise(sum_p2_q[c], mode_p2_q, shift_p2_q));
               pix_p3_d[c*DATA_BW +: DATA_BW] = clamped[DATA_BW-1:0];
               sat_p3_d = sat_p3_d | clamped[DATA_BW];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         pix_p3_q <= '0;
         sat_p3_q <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            coef_q[k] <= '0;
         end
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         vld_p3_q <= vld_p3_d;
         pix_p3_q <= pix_p3_d;
         sat_p3_q <= sat_p3_d;
         coef_q   <= coef_d;
      end
   end

   always_ff @(posedge i_clk) begin
      mode_p1_q  <= mode_p1_d;
      shift_p1_q <= shift_p1_d;
      prod_p1_q  <= prod_p1_d;
      mode_p2_q  <= mode_p2_d;
      shift_p2_q <= shift_p2_d;
      sum_p2_q   <= sum_p2_d;
   end

endmodule

// File: tb/tb_image_conv_pipe.sv
// Randomised and directed scoreboard bench for image_conv_pipe with three channels.
// Expected beats are queued at acceptance and popped by a monitor at each output handshake.
module tb_image_conv_pipe;
   localparam int DBW   = 8;
   localparam int NCH   = 3;
   localparam int CBW   = 8;
   localparam int WIN_W = DBW * 9 * NCH;
   localparam int OUT_W = DBW * NCH;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic             s;
   } exp_t;

   logic             clk = 1'b0;
   logic             rstn;
   logic [2:0]       cfg;
   logic             wr_en;
   logic [3:0]       addr;
   logic [CBW-1:0]   cdata;
   logic [3:0]       ush;
   logic             in_valid;
   logic [WIN_W-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             out_ready;
   logic             sat;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   int   mc[9];
   int   lap1_k[9]  = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
   int   lap2_k[9]  = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
   int   gauss_k[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

   logic             prev_stall = 1'b0;
   logic [OUT_W-1:0] held_d;
   logic             held_s;

   image_conv_pipe #(.DATA_BW(DBW), .NUM_CH(NCH), .COEF_BW(CBW)) dut (
      .i_clk           (clk),
      .i_rstn          (rstn),
      .i_config_select (cfg),
      .i_coef_wr_en    (wr_en),
      .i_coef_addr     (addr),
      .i_coef_data     (cdata),
      .i_user_shift    (ush),
      .i_dxi_in_valid  (in_valid),
      .i_dxi_in_data   (in_data),
      .o_dxi_in_ready  (in_ready),
      .o_dxi_out_valid (out_valid),
      .o_dxi_out_data  (out_data),
      .i_dxi_out_ready (out_ready),
      .o_sat_flag      (sat)
   );

   always #5 clk = ~clk;

   // Reference: kernel sum with plain integers, then the mode's division rule and a clamp.
   function automatic exp_t model(input logic [WIN_W-1:0] w, input logic [2:0] mode, input logic [3:0] sh);
      exp_t e;
      int   s, r, px, kv;
      e.d = '0;
      e.s = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         s = 0;
         for (int k = 0; k < 9; k++) begin
            px = int'(w[c*72 + (8-k)*8 +: 8]);
            case (mode)
               3'd0:    kv = lap1_k[k];
               3'd1:    kv = lap2_k[k];
               3'd2:    kv = gauss_k[k];
               3'd3:    kv = 1;
               default: kv = mc[k];
            endcase
            s += kv * px;
         end
         case (mode)
            3'd0, 3'd1: r = s;
            3'd2:       r = s >>> 4;
            3'd3:       r = s / 9;
            3'd4:       r = s >>> sh;
            default:    r = int'(w[c*72 + 4*8 +: 8]);
         endcase
         if (r < 0) begin
            r = 0;
            e.s = 1'b1;
         end else if (r > 255) begin
            r = 255;
            e.s = 1'b1;
         end
         e.d[c*8 +: 8] = 8'(r);
      end
      return e;
   endfunction

   // Monitor and scoreboard: everything is sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         q.delete();
         for (int k = 0; k < 9; k++) mc[k] = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || out_data !== held_d || sat !== held_s) begin
               errors++;
               $display("FAIL stall_hold got v=%b d=%h s=%b need v=1 d=%h s=%b", out_valid, out_data, sat, held_d, held_s);
            end
         end
         prev_stall = out_valid && !out_ready;
         held_d = out_data;
         held_s = sat;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out got d=%h s=%b with nothing pending", out_data, sat);
            end else begin
               e = q.pop_front();
               if (out_data !== e.d || sat !== e.s) begin
                  errors++;
                  $display("FAIL scoreboard got d=%h s=%b need d=%h s=%b", out_data, sat, e.d, e.s);
               end
            end
         end
         if (in_valid && in_ready) q.push_back(model(in_data, cfg, ush));
         if (wr_en && addr < 4'd9) mc[addr] = int'($signed(cdata));
      end
   end

   function automatic logic [WIN_W-1:0] rep(input logic [71:0] ch);
      return {NCH{ch}};
   endfunction

   function automatic logic [WIN_W-1:0] rand_win();
      logic [WIN_W-1:0] w;
      for (int j = 0; j < WIN_W / 8; j++) begin
         case ($urandom_range(0, 3))
            0:       w[j*8 +: 8] = 8'd0;
            1:       w[j*8 +: 8] = 8'd255;
            default: w[j*8 +: 8] = 8'($urandom);
         endcase
      end
      return w;
   endfunction

   task automatic send(input logic [WIN_W-1:0] w, input logic [2:0] mode, input logic [3:0] sh);
      int n = 0;
      logic acc = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      cfg      = mode;
      ush      = sh;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got ready=0 for %0d cycles need 1", n);
      end
   endtask

   task automatic expect_out(input logic [7:0] px, input logic s, input string nm);
      int n = 0;
      logic got = 1'b0;
      while (!got && n < 50) begin
         @(negedge clk);
         got = out_valid && out_ready;
         n++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s got no output need d=%0d s=%b", nm, px, s);
      end else if (out_data[7:0] !== px || sat !== s) begin
         errors++;
         $display("FAIL %s got d=%0d s=%b need d=%0d s=%b", nm, out_data[7:0], sat, px, s);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d beats outstanding need 0", q.size());
      end
   endtask

   task automatic write_coef(input logic [3:0] a, input logic [CBW-1:0] d);
      wr_en = 1'b1;
      addr  = a;
      cdata = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic check_bit(input logic got, input logic need, input string nm);
      checks++;
      if (got !== need) begin
         errors++;
         $display("FAIL %s got %b need %b", nm, got, need);
      end
   endtask

   initial begin
      logic done;
      rstn = 1'b0; cfg = '0; wr_en = 1'b0; addr = '0; cdata = '0; ush = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      check_bit(out_valid, 1'b0, "rst_valid");
      check_bit(sat, 1'b0, "rst_sat");
      check_bit(out_data == '0, 1'b1, "rst_data");
      check_bit(in_ready, 1'b1, "rst_in_ready");
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Latency: presented in cycle N, valid from cycle N+3.
      send(rep({8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0}), 3'd0, 4'd0);
      @(posedge clk);
      #1;
      check_bit(out_valid, 1'b0, "lat_n2");
      @(posedge clk);
      #1;
      check_bit(out_valid, 1'b1, "lat_n3");
      expect_out(8'd40, 1'b0, "lap1_center");

      send(rep({8'd10, 8'd10, 8'd10, 8'd10, 8'd0, 8'd10, 8'd10, 8'd10, 8'd10}), 3'd0, 4'd0);
      expect_out(8'd0, 1'b1, "lap1_neg");
      send(rep({9{8'd255}}), 3'd1, 4'd0);
      expect_out(8'd0, 1'b0, "lap2_flat");
      send(rep({9{8'd100}}), 3'd2, 4'd0);
      expect_out(8'd100, 1'b0, "gauss_flat");
      send(rep({8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}), 3'd3, 4'd0);
      expect_out(8'd4, 1'b0, "avg_ramp");
      send(rep({9{8'd255}}), 3'd3, 4'd0);
      expect_out(8'd255, 1'b0, "avg_max");

      for (int k = 0; k < 9; k++) write_coef(4'(k), 8'(k));
      send(rep({9{8'd255}}), 3'd4, 4'd2);
      expect_out(8'd255, 1'b1, "user_ramp");
      for (int k = 0; k < 9; k++) write_coef(4'(k), (k == 4) ? 8'hFF : 8'h00);
      send(rep({9{8'd255}}), 3'd4, 4'd0);
      expect_out(8'd0, 1'b1, "user_neg");

      // Coefficient write on the same edge as acceptance: first beat sees -1, second sees +1.
      wr_en = 1'b1; addr = 4'd4; cdata = 8'd1;
      send(rep({9{8'd100}}), 3'd4, 4'd0);
      wr_en = 1'b0;
      send(rep({9{8'd100}}), 3'd4, 4'd0);
      expect_out(8'd0, 1'b1, "wr_same_cycle_old");
      expect_out(8'd100, 1'b0, "wr_next_cycle_new");

      // Backpressure: six back-to-back beats, downstream stalls five cycles after the first output.
      fork
         begin
            for (int i = 0; i < 6; i++) send(rand_win(), 3'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
         end
         begin
            int n = 0;
            while (!out_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            check_bit(out_valid, 1'b1, "bp_first_out");
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (out_valid) check_bit(in_ready, 1'b0, "bp_in_ready");
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Three channels with modes alternating per beat.
      for (int i = 0; i < 9; i++) begin
         logic [2:0] m;
         m = (i % 3 == 0) ? 3'd0 : ((i % 3 == 1) ? 3'd2 : 3'd5);
         send(rand_win(), m, 4'd0);
      end
      drain();

      // Random valid/ready traffic with interleaved coefficient writes.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 5) == 0) begin
                  wr_en = 1'b1;
                  addr  = 4'($urandom_range(0, 15));
                  cdata = 8'($urandom);
               end
               send(rand_win(), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
               wr_en = 1'b0;
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with three beats in flight.
      for (int k = 0; k < 9; k++) write_coef(4'(k), 8'd1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(rep({9{8'd200}}), 3'd4, 4'd0);
      check_bit(out_valid, 1'b1, "pre_reset_valid");
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      #1;
      check_bit(out_valid, 1'b0, "mid_rst_valid");
      check_bit(sat, 1'b0, "mid_rst_sat");
      check_bit(out_data == '0, 1'b1, "mid_rst_data");
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         check_bit(out_valid, 1'b0, "post_rst_no_out");
      end
      send(rep({9{8'd200}}), 3'd4, 4'd0);
      expect_out(8'd0, 1'b0, "coef_cleared");
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish within time limit need finish");
      $fatal(1);
   end

endmodule
